registro_banderas_alu: RTL
==========================

// Module: registro_banderas_alu
// PURPOSE
// - Output stage downstream of the ALU datapath. Accepts each ALU result plus the ALU's carry and
//   overflow, and computes the zero, sign and parity flags (ZF = NOR of all result bits).
// - Buffers results in a 2-entry in-order queue with valid/ready on both sides.
// - Presents registered result+flag words to the consumer (display/status logic).
// PARAMETERS
// - WIDTH  6  result width in bits (>=2); flags are computed over all WIDTH bits
// PORTS
// - CLK        in   1      single clock; all state updates on rising edge
// - RST        in   1      synchronous, active-high reset
// - Dato_in    in   WIDTH  ALU result
// - CF_in      in   1      ALU carry/borrow out
// - OF_in      in   1      ALU signed overflow
// - Valid_in   in   1      Dato_in/CF_in/OF_in valid this cycle
// - Ready_in   out  1      stage can accept; transfer when Valid_in & Ready_in
// - Dato_out   out  WIDTH  head-entry result
// - ZF_out     out  1      head: 1 when Dato_out == 0
// - SF_out     out  1      head: Dato_out[WIDTH-1]
// - PF_out     out  1      head: 1 when Dato_out has an even number of 1s (~^Dato_out)
// - CF_out     out  1      head: captured CF_in
// - OF_out     out  1      head: captured OF_in
// - Valid_out  out  1      head entry valid
// - Ready_out  in   1      consumer takes head when Valid_out & Ready_out
// - CLR_STICKY in   1      clears OF_STICKY (see CONFIGURATION)
// - OF_STICKY  out  1      accumulated overflow (see CONFIGURATION)
// BEHAVIOUR
// - Storage: 2 entries. Each entry holds {Dato, CF, OF, ZF, SF, PF}. Flags are computed at push
//   time from Dato_in and stored with it. No flag is computed combinationally from Dato_out.
// - Occupancy count 0..2. Ready_in = (count < 2). Ready_in comes from registered state only and
//   has no combinational path from Ready_out.
// - Push = Valid_in & Ready_in. Pop = Valid_out & Ready_out. Valid_out = (count != 0).
// - Latency: an entry pushed at edge N is visible on the outputs with Valid_out=1 after edge N.
//   This is 1 cycle, also when count was 0.
// - Order: strict FIFO. Head outputs stay stable while Valid_out=1 and Ready_out=0.
// - Simultaneous push+pop at count=1: count stays 1. The new entry becomes head after the edge.
// - count=2: Ready_in=0, so Valid_in is ignored and no data is lost or overwritten.
//   A pop at count=2 gives Ready_in=1 on the next cycle.
// - Pop at count=0 is impossible (Valid_out=0). Ready_out is ignored.
// - Pointers: 1-bit rd/wr pointers that wrap 1->0.
// - Reset (also mid-transfer): count=0, pointers=0, all entries flushed. Reset values:
//   - Valid_out=0, Dato_out=0, ZF/SF/PF/CF/OF_out=0, OF_STICKY=0.
//   - Ready_in=1 on the first cycle after reset deasserts.
//   - A push coincident with RST=1 is discarded.
// - Outputs when Valid_out=0: Dato_out and the flags hold their last values and must not be used.
//   After reset they are 0.
// CONFIGURATION
// - Macro STICKY_OF_EN defined:
//   - OF_STICKY sets to 1 at the edge where a popped entry has OF=1.
//   - OF_STICKY stays 1 until CLR_STICKY=1 or RST.
//   - CLR_STICKY together with a pop of OF=1 in the same cycle: set wins, OF_STICKY=1.
//   - The CLR_STICKY clear takes effect at the next edge.
// - Macro not defined: OF_STICKY tied to 0 and CLR_STICKY ignored. Both ports remain present.
//   No sticky register is synthesised.
// TESTING
// - Reset then idle:
//   - Outputs: Valid_out=0, Ready_in=1, all flags 0.
//   - Assert RST during count=2: next cycle count=0 and Valid_out=0.
// - Single pushes with Ready_out=1:
//   - Dato_in=6'b000000 -> ZF=1 SF=0 PF=1 one cycle later.
//   - Dato_in=6'b100001 -> ZF=0 SF=1 PF=1.
//   - Dato_in=6'b000111 -> PF=0.
// - Backpressure:
//   - With Ready_out=0, push 6'h05 then 6'h2A. Ready_in drops after the 2nd push.
//   - A third Valid_in with 6'h3F is ignored.
//   - Release Ready_out: the bench sees 6'h05 then 6'h2A, in order.
// - Steady stream:
//   - Valid_in=1 and Ready_out=1 each cycle with values 0..63.
//   - Throughput 1 result/cycle, count stays 1, all 64 results arrive in order with correct flags.
// - Flag pass-through:
//   - Push CF_in=1,OF_in=0 then CF_in=0,OF_in=1.
//   - Outputs show CF_out/OF_out = 1/0 then 0/1.
// - STICKY_OF_EN:
//   - Pop an entry with OF=1 -> OF_STICKY=1. It holds across later OF=0 pops.
//   - CLR_STICKY -> 0. CLR_STICKY together with an OF=1 pop -> stays 1.
//   - Without the macro, OF_STICKY stays 0 throughout.

Source files
------------

// File: rtl/registro_banderas_alu_if.sv
// Result/flag bus between the ALU flag stage and its consumer.
// slave = flag stage view, master = producer/consumer (testbench) view.
interface registro_banderas_alu_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] Dato_in;
    logic             CF_in;
    logic             OF_in;
    logic             Valid_in;
    logic             Ready_in;
    logic [WIDTH-1:0] Dato_out;
    logic             ZF_out;
    logic             SF_out;
    logic             PF_out;
    logic             CF_out;
    logic             OF_out;
    logic             Valid_out;
    logic             Ready_out;
    logic             CLR_STICKY;
    logic             OF_STICKY;

    modport slave (
        input  Dato_in, CF_in, OF_in, Valid_in, Ready_out, CLR_STICKY,
        output Ready_in, Dato_out, ZF_out, SF_out, PF_out, CF_out, OF_out,
               Valid_out, OF_STICKY
    );

    modport master (
        output Dato_in, CF_in, OF_in, Valid_in, Ready_out, CLR_STICKY,
        input  Ready_in, Dato_out, ZF_out, SF_out, PF_out, CF_out, OF_out,
               Valid_out, OF_STICKY
    );
endinterface

// File: rtl/registro_banderas_alu.sv
// ALU flag stage: 2-entry in-order queue of {result, CF, OF, ZF, SF, PF} with registered head.
// Define STICKY_OF_EN to build the accumulated-overflow register (OF_STICKY/CLR_STICKY).
module registro_banderas_alu #(
    parameter int WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    registro_banderas_alu_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] dato;
        logic             cf;
        logic             of;
        logic             zf;
        logic             sf;
        logic             pf;
    } entry_t;

    entry_t     r_mem [2];
    entry_t     r_head;
    logic [1:0] r_count;
    logic       r_wr_ptr;
    logic       r_rd_ptr;

    entry_t     w_in;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_rem;
    logic       w_rd_ptr_n;

    assign w_push     = bus.Valid_in && (r_count != 2'd2);
    assign w_pop      = (r_count != 2'd0) && bus.Ready_out;
    assign w_rem      = r_count - {1'b0, w_pop};
    assign w_rd_ptr_n = r_rd_ptr ^ w_pop;

    always_comb begin
        w_in      = '0;
        w_in.dato = bus.Dato_in;
        w_in.cf   = bus.CF_in;
        w_in.of   = bus.OF_in;
        w_in.zf   = ~|bus.Dato_in;
        w_in.sf   = bus.Dato_in[WIDTH-1];
        w_in.pf   = ~^bus.Dato_in;
    end

    // Head register is loaded with whatever will be at the front after this edge:
    // a surviving stored entry, else the entry being pushed; otherwise it holds.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= '0;
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            r_rd_ptr <= w_rd_ptr_n;
            r_count  <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_rem != 2'd0)
                r_head <= r_mem[w_rd_ptr_n];
            else if (w_push)
                r_head <= w_in;
        end
    end

    assign bus.Ready_in  = (r_count != 2'd2);
    assign bus.Valid_out = (r_count != 2'd0);
    assign bus.Dato_out  = r_head.dato;
    assign bus.CF_out    = r_head.cf;
    assign bus.OF_out    = r_head.of;
    assign bus.ZF_out    = r_head.zf;
    assign bus.SF_out    = r_head.sf;
    assign bus.PF_out    = r_head.pf;

`ifdef STICKY_OF_EN
    logic r_of_sticky;

    // A popped overflow takes priority over a clear in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST)
            r_of_sticky <= 1'b0;
        else if (w_pop && r_head.of)
            r_of_sticky <= 1'b1;
        else if (bus.CLR_STICKY)
            r_of_sticky <= 1'b0;
    end

    assign bus.OF_STICKY = r_of_sticky;
`else
    logic w_unused_clr;

    assign w_unused_clr  = bus.CLR_STICKY;
    assign bus.OF_STICKY = 1'b0;
`endif
endmodule
